// File: rtl/gf163_pkg.sv
// Shared definitions for the digit-serial GF(2^163) multiplier, f(x) = x^163 + x^7 + x^6 + x^3 + 1.
package gf163_pkg;

  localparam int M = 163;

  // Low-order taps of f(x): x^7 + x^6 + x^3 + 1
  localparam logic [M-1:0] F_TAPS = 163'hC9;

  typedef logic [M-1:0] gf_elem_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ndig(input int d);
    return (M + d - 1) / d;
  endfunction

  function automatic bit d_legal(input int d);
    return (d == 1) || (d == 2) || (d == 4) || (d == 8);
  endfunction

endpackage

// File: rtl/gf163_digit_step.sv
// One Horner step: acc*x^D + a*d, reduced mod f(x) with a single fold of the D overflow bits.
module gf163_digit_step
  import gf163_pkg::*;
#(
  parameter int D = 2
) (
  input  gf_elem_t       i_acc,
  input  gf_elem_t       i_a,
  input  logic [D-1:0]   i_d,
  output gf_elem_t       o_acc
);

  logic [M+D-1:0] w_wide;
  logic [D-1:0]   w_hi;
  gf_elem_t       w_hi_ext;

  always_comb begin
    w_wide = {i_acc, {D{1'b0}}};
    for (int i = 0; i < D; i++) begin
      if (i_d[i]) begin
        w_wide = w_wide ^ ({{D{1'b0}}, i_a} << i);
      end
    end
    w_hi     = w_wide[M+D-1:M];
    w_hi_ext = gf_elem_t'(w_hi);
    // x^M == x^7 + x^6 + x^3 + 1; with D <= 8 the folded bits stay below x^M
    o_acc    = w_wide[M-1:0] ^ w_hi_ext ^ (w_hi_ext << 3) ^ (w_hi_ext << 6) ^ (w_hi_ext << 7);
  end

endmodule

// File: rtl/gf163_mult_seq.sv
// Sequencer/accumulator for the digit-serial GF(2^163) multiplier; walks B MSB digit first.
module gf163_mult_seq
  import gf163_pkg::*;
#(
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_a,
  input  logic [M-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_c,
  output logic         busy
);

  localparam int NDIG = ndig(D);
  localparam int NBW  = NDIG * D;
  localparam int CW   = $clog2(NDIG);

  state_t           r_state;
  gf_elem_t         r_a;
  logic [NBW-1:0]   r_b;
  gf_elem_t         r_acc;
  logic [CW-1:0]    r_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  gf_elem_t         w_step;

  gf163_digit_step #(.D(D)) u_step (
    .i_acc (r_acc),
    .i_a   (r_a),
    .i_d   (r_b[NBW-1 -: D]),
    .o_acc (w_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= in_a;
            r_b        <= NBW'(in_b);
            r_acc      <= '0;
            r_count    <= CW'(NDIG - 1);
            r_state    <= RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          r_acc <= w_step;
          r_b   <= r_b << D;
          if (r_count == '0) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        DONE: begin
          // in_ready returns only on the edge after consumption, so no same-cycle accept
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_c     = r_acc;

endmodule

// File: tb/tb_gf163_mult_seq.sv
// Self-checking bench for gf163_mult_seq: directed table, random pairs with back-pressure,
// mid-run reset, and latency/result regressions at D = 1, 4, 8.
module tb_gf163_mult_seq;

  typedef logic [162:0] gf_t;

  typedef struct {
    gf_t   a;
    gf_t   b;
    gf_t   c;
    string nm;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic in_valid = 1'b0;
  logic in_ready;
  gf_t  in_a = '0;
  gf_t  in_b = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  gf_t  out_c;
  logic busy;

  logic       x_valid = 1'b0;
  gf_t        x_a = '0;
  gf_t        x_b = '0;
  logic [2:0] x_ready;
  logic [2:0] x_ov;
  logic [2:0] x_busy;
  gf_t        x_c [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gf163_mult_seq #(.D(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .busy(busy)
  );

  gf163_mult_seq #(.D(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x_ready[0]), .in_a(x_a), .in_b(x_b),
    .out_valid(x_ov[0]), .out_ready(1'b1), .out_c(x_c[0]), .busy(x_busy[0])
  );

  gf163_mult_seq #(.D(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x_ready[1]), .in_a(x_a), .in_b(x_b),
    .out_valid(x_ov[1]), .out_ready(1'b1), .out_c(x_c[1]), .busy(x_busy[1])
  );

  gf163_mult_seq #(.D(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x_ready[2]), .in_a(x_a), .in_b(x_b),
    .out_valid(x_ov[2]), .out_ready(1'b1), .out_c(x_c[2]), .busy(x_busy[2])
  );

  // Reference: schoolbook polynomial product, then long division by f(x).
  function automatic gf_t gf_mul(input gf_t a, input gf_t b);
    logic [324:0] p;
    logic [324:0] f;
    p = '0;
    f = (325'(1) << 163) | 325'hC9;
    for (int i = 0; i < 163; i++) begin
      if (b[i]) p = p ^ (325'(a) << i);
    end
    for (int j = 324; j >= 163; j--) begin
      if (p[j]) p = p ^ (f << (j - 163));
    end
    return p[162:0];
  endfunction

  function automatic gf_t rand_gf();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[162:0];
  endfunction

  task automatic chk(input string nm, input gf_t act, input gf_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_mult(input gf_t a, input gf_t b, input gf_t exp, input string nm, input int bp);
    int  n;
    int  m;
    bit  bad;
    bit  got;
    bit  held;
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, " ready_before"}, gf_t'(in_ready), gf_t'(1));
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = rand_gf(); in_b = rand_gf();
    n = 0; bad = 1'b0; got = 1'b0;
    while (n < 200) begin
      out_ready = 1'($urandom_range(1));
      @(posedge clk); #1; n++;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      if (in_ready || !busy) bad = 1'b1;
    end
    out_ready = 1'b0;
    chk({nm, " done_seen"}, gf_t'(got), gf_t'(1));
    chk({nm, " latency"}, gf_t'(n), gf_t'(82));
    if (!got) return;
    m = 0; held = 1'b0;
    while (out_valid && m < 300) begin
      chk({nm, " out_c"}, out_c, exp);
      if (in_ready || !busy) bad = 1'b1;
      held = ($urandom_range(99) >= bp);
      out_ready = held;
      @(posedge clk); #1; m++;
      if (held) break;
    end
    out_ready = 1'b0;
    chk({nm, " consumed_by_ready"}, gf_t'(held), gf_t'(1));
    chk({nm, " valid_dropped"}, gf_t'(out_valid), gf_t'(0));
    chk({nm, " ready_back"}, gf_t'(in_ready), gf_t'(1));
    chk({nm, " ready_low_while_busy"}, gf_t'(bad), gf_t'(0));
  endtask

  task automatic multi_d(input gf_t a, input gf_t b, input string nm);
    int  n;
    int  lat [3];
    bit  seen [3];
    int  exp_lat [3];
    gf_t exp;
    exp_lat = '{163, 41, 21};
    exp = gf_mul(a, b);
    n = 0;
    while (x_ready != 3'b111 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, " x_ready"}, gf_t'(x_ready), gf_t'(3'b111));
    x_a = a; x_b = b; x_valid = 1'b1;
    @(posedge clk); #1;
    x_valid = 1'b0;
    x_a = rand_gf(); x_b = rand_gf();
    for (int j = 0; j < 3; j++) begin
      seen[j] = 1'b0; lat[j] = 0;
    end
    n = 0;
    while (!(seen[0] && seen[1] && seen[2]) && n < 250) begin
      @(posedge clk); #1; n++;
      for (int j = 0; j < 3; j++) begin
        if (!seen[j] && x_ov[j]) begin
          seen[j] = 1'b1;
          lat[j]  = n;
          chk($sformatf("%s d_idx%0d out_c", nm, j), x_c[j], exp);
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s d_idx%0d latency", nm, j), gf_t'(lat[j]), gf_t'(exp_lat[j]));
    end
  endtask

  vec_t vt [6];

  initial begin
    gf_t ra;
    gf_t rb;
    int  n;
    bit  pulse;

    ra = rand_gf();
    rb = rand_gf();
    vt[0] = '{163'd1, 163'd1, 163'd1, "one_x_one"};
    vt[1] = '{gf_t'(1) << 162, 163'd2, 163'hC9, "x162_x_x"};
    vt[2] = '{ra, 163'd0, 163'd0, "rand_x_zero"};
    vt[3] = '{163'd0, rb, 163'd0, "zero_x_rand"};
    vt[4] = '{163'd3, 163'd5, 163'd15, "three_x_five"};
    vt[5] = '{~163'd0, ~163'd0, gf_mul(~163'd0, ~163'd0), "ones_x_ones"};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", gf_t'(in_ready), gf_t'(1));
    chk("reset out_valid", gf_t'(out_valid), gf_t'(0));
    chk("reset busy", gf_t'(busy), gf_t'(0));
    chk("reset out_c", out_c, gf_t'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      do_mult(vt[i].a, vt[i].b, vt[i].c, vt[i].nm, 0);
    end

    for (int i = 0; i < 400; i++) begin
      ra = rand_gf();
      rb = rand_gf();
      do_mult(ra, rb, gf_mul(ra, rb), $sformatf("rand%0d", i), 60);
    end

    // Abandon a multiply at iteration 40 with a one-edge reset
    in_a = rand_gf(); in_b = rand_gf(); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrun_reset in_ready", gf_t'(in_ready), gf_t'(1));
    chk("midrun_reset out_valid", gf_t'(out_valid), gf_t'(0));
    chk("midrun_reset busy", gf_t'(busy), gf_t'(0));
    chk("midrun_reset out_c", out_c, gf_t'(0));
    pulse = 1'b0;
    for (n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (out_valid || busy) pulse = 1'b1;
    end
    chk("midrun_reset no_pulse", gf_t'(pulse), gf_t'(0));
    do_mult(163'd3, 163'd5, 163'd15, "after_reset_3x5", 0);

    multi_d(163'd1, 163'd1, "md_one");
    multi_d(gf_t'(1) << 162, 163'd2, "md_x162");
    for (int i = 0; i < 4; i++) begin
      multi_d(rand_gf(), rand_gf(), $sformatf("md_rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
